// File: rtl/triplet_loader_pkg.sv
// Shared definitions for the triplet loader, comparator and lab wrapper.
package triplet_loader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  // Loader FSM encoding: three collecting states plus the presenting state.
  localparam logic [1:0] S_X    = 2'd0;
  localparam logic [1:0] S_Y    = 2'd1;
  localparam logic [1:0] S_Z    = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

endpackage

// File: rtl/triplet_loader_if.sv
// Byte-in / triplet-out handshake bundle between source, loader and consumer.
interface triplet_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic [DATA_W-1:0] z;
  logic              out_valid;
  logic              out_ready;

  // Environment side: drives samples and consumer acceptance.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, x, y, z, out_valid
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, x, y, z, out_valid
  );
endinterface

// File: rtl/triplet_loader_wrap_counter.sv
// Free-running modulo-2^CNT_W event counter with enable.
module wrap_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  // Next count: natural wrap from all-ones back to zero.
  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/triplet_loader.sv
// Groups a byte stream into registered (x, y, z) triplets for the max comparator.
module triplet_loader
  import triplet_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  triplet_loader_if.slave  bus,
  output logic [CNT_W-1:0] triplet_count
);
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic              out_valid_q, out_valid_d;
  logic              take;
  logic              cnt_en;

  // Ready while collecting, or in FULL when the consumer frees the slot this
  // cycle; never during reset or a flush cycle.
  always_comb begin
    bus.in_ready = rst_n & ~flush & ((state_q != S_FULL) | bus.out_ready);
  end

  assign take   = bus.in_valid & bus.in_ready;
  assign cnt_en = out_valid_q & bus.out_ready & ~flush;

  // FSM next state and x/y/z capture; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = S_X;
      x_d         = '0;
      y_d         = '0;
      z_d         = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_X: if (take) begin
          x_d     = bus.in_data;
          state_d = S_Y;
        end
        S_Y: if (take) begin
          y_d     = bus.in_data;
          state_d = S_Z;
        end
        S_Z: if (take) begin
          z_d         = bus.in_data;
          state_d     = S_FULL;
          out_valid_d = 1'b1;
        end
        default: if (bus.out_ready) begin
          // Triplet accepted; a byte arriving now starts the next one with no bubble.
          out_valid_d = 1'b0;
          if (take) begin
            x_d     = bus.in_data;
            state_d = S_Y;
          end else begin
            state_d = S_X;
          end
        end
      endcase
    end
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_X;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.z         = z_q;
  assign bus.out_valid = out_valid_q;

  wrap_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .count (triplet_count)
  );
endmodule

// File: tb/tb_triplet_loader.sv
// Self-checking bench: vector table, hand sequences and random stimulus vs model.
module tb_triplet_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  triplet_loader_if #(.DATA_W(8)) bus ();
  triplet_loader_if #(.DATA_W(8)) bus2 ();

  assign bus2.in_data   = bus.in_data;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.out_ready = bus.out_ready;

  triplet_loader #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .triplet_count(cnt8)
  );
  triplet_loader #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2), .triplet_count(cnt2)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_x, m_y, m_z, m_pos, m_cnt;
  bit m_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_z = 0; m_pos = 0; m_cnt = 0; m_full = 0;
  endtask

  function automatic bit model_ready();
    return rst_n && !flush && (!m_full || bus.out_ready);
  endfunction

  task automatic model_check();
    chk("m_x", 32'(bus.x), 32'(m_x & 8'hff));
    chk("m_y", 32'(bus.y), 32'(m_y & 8'hff));
    chk("m_z", 32'(bus.z), 32'(m_z & 8'hff));
    chk("m_out_valid", 32'(bus.out_valid), 32'(m_full));
    chk("m_in_ready", 32'(bus.in_ready), 32'(model_ready()));
    chk("m_count8", 32'(cnt8), 32'(m_cnt % 256));
    chk("m_count2", 32'(cnt2), 32'(m_cnt % 4));
  endtask

  // Apply one clock edge's worth of the loader rules.
  task automatic model_step();
    bit take;
    take = bus.in_valid && model_ready();
    if (flush) begin
      model_reset_data();
      return;
    end
    if (m_full && bus.out_ready) begin
      m_cnt++;
      m_full = 0;
    end
    if (take) begin
      if (m_pos == 0)      m_x = int'(bus.in_data);
      else if (m_pos == 1) m_y = int'(bus.in_data);
      else                 m_z = int'(bus.in_data);
      m_pos++;
      if (m_pos == 3) begin
        m_pos  = 0;
        m_full = 1;
      end
    end
  endtask

  task automatic model_reset_data();
    m_x = 0; m_y = 0; m_z = 0; m_pos = 0; m_full = 0;
  endtask

  task automatic pre();
    @(negedge clk);
    if (!rst_n) model_reset();
    model_check();
  endtask

  task automatic post();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [7:0] d, input bit ordy, input bit fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit iv; logic [7:0] d; bit ordy; bit fl;
    logic [7:0] ex, ey, ez; bit eov; bit eir; int ecnt;
  } vec_t;
  vec_t vecs[$];

  function automatic void r(input bit iv, input logic [7:0] d, input bit ordy, input bit fl,
                            input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] ez,
                            input bit eov, input bit eir, input int ecnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ex = ex; v.ey = ey; v.ez = ez; v.eov = eov; v.eir = eir; v.ecnt = ecnt;
    vecs.push_back(v);
  endfunction

  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    drive(0, 8'h00, 0, 0);
    model_reset();

    // basic triplet with immediate accept
    r(1, 8'h10, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    r(1, 8'h20, 1, 0, 8'h10, 8'h00, 8'h00, 0, 1, 0);
    r(1, 8'h30, 1, 0, 8'h10, 8'h20, 8'h00, 0, 1, 0);
    r(0, 8'h00, 1, 0, 8'h10, 8'h20, 8'h30, 1, 1, 0);
    r(0, 8'h00, 1, 0, 8'h10, 8'h20, 8'h30, 0, 1, 1);
    // back-pressure: 0x99 waits five cycles, then becomes the next x
    r(1, 8'h40, 0, 0, 8'h10, 8'h20, 8'h30, 0, 1, 1);
    r(1, 8'h50, 0, 0, 8'h40, 8'h20, 8'h30, 0, 1, 1);
    r(1, 8'h60, 0, 0, 8'h40, 8'h50, 8'h30, 0, 1, 1);
    for (int i = 0; i < 5; i++) r(1, 8'h99, 0, 0, 8'h40, 8'h50, 8'h60, 1, 0, 1);
    r(1, 8'h99, 1, 0, 8'h40, 8'h50, 8'h60, 1, 1, 1);
    r(1, 8'h05, 0, 0, 8'h99, 8'h50, 8'h60, 0, 1, 2);
    r(1, 8'h06, 0, 0, 8'h99, 8'h05, 8'h60, 0, 1, 2);
    // flush coinciding with an accept: not counted
    r(1, 8'h07, 1, 1, 8'h99, 8'h05, 8'h06, 1, 0, 2);
    // partial triplet then flush
    r(1, 8'h05, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 2);
    r(1, 8'h06, 1, 0, 8'h05, 8'h00, 8'h00, 0, 1, 2);
    r(1, 8'h77, 1, 1, 8'h05, 8'h06, 8'h00, 0, 0, 2);
    r(1, 8'h0A, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 2);
    r(1, 8'h0B, 1, 0, 8'h0A, 8'h00, 8'h00, 0, 1, 2);
    r(1, 8'h0C, 1, 0, 8'h0A, 8'h0B, 8'h00, 0, 1, 2);
    r(0, 8'h00, 1, 0, 8'h0A, 8'h0B, 8'h0C, 1, 1, 2);
    r(0, 8'h00, 1, 0, 8'h0A, 8'h0B, 8'h0C, 0, 1, 3);

    // reset state
    pre();
    chk("rst_x", 32'(bus.x), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_count", 32'(cnt8), 0);
    post();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      pre();
      chk($sformatf("v%0d_x", i), 32'(bus.x), 32'(vecs[i].ex));
      chk($sformatf("v%0d_y", i), 32'(bus.y), 32'(vecs[i].ey));
      chk($sformatf("v%0d_z", i), 32'(bus.z), 32'(vecs[i].ez));
      chk($sformatf("v%0d_ov", i), 32'(bus.out_valid), 32'(vecs[i].eov));
      chk($sformatf("v%0d_ir", i), 32'(bus.in_ready), 32'(vecs[i].eir));
      chk($sformatf("v%0d_cnt", i), 32'(cnt8), 32'(vecs[i].ecnt));
      post();
    end

    // back-to-back 1..9, no idle cycles between triplets
    for (int i = 0; i < 10; i++) begin
      drive(i < 9, 8'(i + 1), 1, 0);
      pre();
      chk($sformatf("b2b%0d_ir", i), 32'(bus.in_ready), 1);
      chk($sformatf("b2b%0d_ov", i), 32'(bus.out_valid), 32'(i == 3 || i == 6 || i == 9));
      if (i == 3 || i == 6 || i == 9) begin
        chk($sformatf("b2b%0d_xyz", i), {8'h0, bus.x, bus.y, bus.z},
            {8'h0, 8'(i - 2), 8'(i - 1), 8'(i)});
      end
      post();
    end
    drive(0, 8'h00, 1, 0);
    pre();
    chk("b2b_count", 32'(cnt8), 6);
    post();

    // reset mid-triplet
    drive(1, 8'h55, 1, 0);
    pre(); post();
    drive(1, 8'h66, 1, 0);
    pre(); post();
    rst_n = 1'b0;
    pre();
    chk("mid_rst_x", 32'(bus.x), 0);
    chk("mid_rst_count", 32'(cnt8), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
    post();
    rst_n = 1'b1;

    // five triplets on the 2-bit counter: 1,2,3,0,1
    for (int t = 0; t < 5; t++) begin
      for (int b = 0; b < 3; b++) begin
        drive(1, 8'(16 * t + b), 1, 0);
        pre(); post();
      end
      drive(0, 8'h00, 1, 0);
      pre(); post();
      pre();
      chk($sformatf("wrap%0d", t), 32'(cnt2), 32'(wrap_exp[t]));
      post();
    end

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 7,
            $urandom_range(0, 29) == 0);
      pre(); post();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
